alu_issue_ctrl: RTL

- Sequences and shares the single 32-bit ALU between two requesters: req0 (CPU pipeline) and req1 (auxiliary/debug or coprocessor port).
- Round-robin arbitration; operands registered before driving the ALU.
- Multi-cycle ops (ALU mcp flag, e.g. wide MUL) get extra settle cycles; per-requester carry/overflow flags held here and fed back as cin/vin.
- Results returned on a valid/ready response channel tagged with the requester id.

---
 rtl/alu_issue_ctrl_pkg.sv | 18 +
 rtl/alu_issue_ctrl_rr_arb2.sv | 21 ++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared state encodings, id width, opcode values and request record
package alu_issue_ctrl_pkg;
    localparam int ID_W = 1;
    localparam logic [1:0] ALUQ_IDLE = 2'd0;
    localparam logic [1:0] ALUQ_EXEC = 2'd1;
    localparam logic [1:0] ALUQ_MCPW = 2'd2;
    localparam logic [1:0] ALUQ_RESP = 2'd3;
    localparam logic [5:0] OP_ADD = 6'h01;
    localparam logic [5:0] OP_SUB = 6'h02;
    localparam logic [5:0] OP_MOV = 6'h03;
    localparam logic [5:0] OP_ROL = 6'h04;
    localparam logic [5:0] OP_MUL = 6'h05;
    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } alu_req_t;
endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// alu_rr_arb2: two-way round-robin arbiter; prio_q names the winner when both requesters are valid
module alu_rr_arb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o,
    output logic       gnt_id_o
);
    logic prio_q;
    assign gnt_id_o = valid_i[1] & (~valid_i[0] | prio_q);
    assign grant_o  = (valid_i == 2'b00) ? 2'b00 : (gnt_id_o ? 2'b10 : 2'b01);
    always_ff @(posedge clk) begin
        if (!reset_b)
            prio_q <= RR_INIT;
        else if (accept_i)
            prio_q <= ~gnt_id_o;
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: shares one ALU between two requesters with round-robin issue and per-requester C/V flags
// Define ALU_ISSUE_B2B_EN to arbitrate during the response handover for one op per 2 cycles.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned MCP_CYCLES = 1,
    parameter int unsigned RR_INIT    = 0
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_opcode,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_opcode,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_opcode,
    output logic        alu_cin,
    output logic        alu_vin,
    input  logic [31:0] alu_dout,
    input  logic        alu_cout,
    input  logic        alu_vout,
    input  logic        alu_mcp,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [ID_W-1:0] rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_cout,
    output logic        rsp_vout,
    output logic [1:0]  c_flag,
    output logic [1:0]  v_flag
);
    logic [1:0]      state_q, state_d;
    alu_req_t        req_q;
    logic [ID_W-1:0] id_q;
    logic [2:0]      cnt_q;
    logic [1:0]      c_q, v_q;
    logic [31:0]     data_q;
    logic            rc_q, rv_q;
    logic [1:0]      gnt;
    logic            gnt_id, arb_en, accept, cap;

    alu_rr_arb2 #(.RR_INIT(RR_INIT != 0)) u_arb (
        .clk      (clk),
        .reset_b  (reset_b),
        .valid_i  ({req1_valid, req0_valid}),
        .accept_i (accept),
        .grant_o  (gnt),
        .gnt_id_o (gnt_id)
    );

`ifdef ALU_ISSUE_B2B_EN
    assign arb_en = (state_q == ALUQ_IDLE) || (state_q == ALUQ_RESP && rsp_ready);
`else
    assign arb_en = (state_q == ALUQ_IDLE);
`endif
    assign accept     = arb_en & (req0_valid | req1_valid);
    assign req0_ready = arb_en & gnt[0];
    assign req1_ready = arb_en & gnt[1];
    assign cap        = (state_q == ALUQ_EXEC && !alu_mcp) || (state_q == ALUQ_MCPW && cnt_q == 3'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ALUQ_IDLE: state_d = accept ? ALUQ_EXEC : ALUQ_IDLE;
            ALUQ_EXEC: state_d = alu_mcp ? ALUQ_MCPW : ALUQ_RESP;
            ALUQ_MCPW: state_d = (cnt_q == 3'd1) ? ALUQ_RESP : ALUQ_MCPW;
            default:   state_d = !rsp_ready ? ALUQ_RESP : (accept ? ALUQ_EXEC : ALUQ_IDLE);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state_q <= ALUQ_IDLE;
            req_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
            v_q     <= '0;
            data_q  <= '0;
            rc_q    <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q <= gnt_id ? {req1_opcode, req1_a, req1_b} : {req0_opcode, req0_a, req0_b};
                id_q  <= gnt_id;
            end
            if (state_q == ALUQ_EXEC)
                cnt_q <= 3'(MCP_CYCLES);
            else if (state_q == ALUQ_MCPW)
                cnt_q <= cnt_q - 3'd1;
            if (cap) begin
                data_q    <= alu_dout;
                rc_q      <= alu_cout;
                rv_q      <= alu_vout;
                c_q[id_q] <= alu_cout;
                v_q[id_q] <= alu_vout;
            end
        end
    end

    assign alu_a      = req_q.a;
    assign alu_b      = req_q.b;
    assign alu_opcode = req_q.op;
    assign alu_cin    = c_q[id_q];
    assign alu_vin    = v_q[id_q];
    assign rsp_valid  = (state_q == ALUQ_RESP);
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_cout   = rc_q;
    assign rsp_vout   = rv_q;
    assign c_flag     = c_q;
    assign v_flag     = v_q;
endmodule
